// File: rtl/conv_row_sequencer_if.sv
// Handshake bundle between the row sequencer and the conv unit array.
// The sequencer drives the receptive-field coordinates and the start
// strobe; the conv array returns one half-row of results per strobe.
interface conv_row_sequencer_if #(
    parameter int DATA_WIDTH = 4,
    parameter int HALF       = 6
);
    logic [5:0]                 rowNumber;
    logic [5:0]                 column;
    logic                       conv_start;
    logic                       conv_done;
    logic [HALF*DATA_WIDTH-1:0] conv_result;   // element 0 in the top DATA_WIDTH bits

    modport master (
        output rowNumber, column, conv_start,
        input  conv_done, conv_result
    );

    modport slave (
        input  rowNumber, column, conv_start,
        output conv_done, conv_result
    );
endinterface

// File: rtl/conv_row_sequencer.sv
// Frame-level sequencer ahead of the receptive-field selector.
// Walks output rows 0..OH-1 and column halves 0/1, strobes the conv array
// once per half-row and packs the returned half-rows into out_image
// (element 0 of the map in the top DATA_WIDTH bits, row-major).
// Optional feature: define CONV_SEQ_TIMEOUT_EN to enable a WAIT-state
// watchdog that aborts the frame and sets a sticky timeout_err.

// One half-row slice of the output map.
module conv_blk_reg #(
    parameter int BW = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [BW-1:0] d,
    output logic [BW-1:0] q
);
    // Slice register: loads the conv result when this half-row is addressed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     q <= '0;
        else if (wr_en) q <= d;
    end
endmodule

module conv_row_sequencer #(
    parameter int DATA_WIDTH     = 4,
    parameter int H              = 16,
    parameter int W              = 16,
    parameter int F              = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         start,
    output logic                                         busy,
    output logic                                         done,
    conv_row_sequencer_if.master                         conv,
    output logic [(H-F+1)*(W-F+1)*DATA_WIDTH-1:0]        out_image,
    output logic                                         timeout_err
);
    localparam int OW    = W - F + 1;
    localparam int OH    = H - F + 1;
    localparam int HALF  = OW / 2;
    localparam int HB    = HALF * DATA_WIDTH;
    localparam int NBLK  = 2 * OH;
    localparam int IMG_W = OH * OW * DATA_WIDTH;

    // Static configuration sanity: the map must split into two equal halves.
    if ((OW % 2) != 0 || OH < 1 || TIMEOUT_CYCLES < 1) begin : g_cfg_err
        $error("conv_row_sequencer: bad configuration");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

    state_t     state_q, state_d;
    logic [5:0] row_q, row_d;
    logic [5:0] col_q, col_d;
    logic       conv_start_q;
    logic       wr_en;
    logic [6:0] blk_idx;
    logic [NBLK-1:0][HB-1:0] blk_q;

`ifdef CONV_SEQ_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    // Half-row index into the map: two halves per output row.
    assign blk_idx = {row_q, col_q[0]};

    assign conv.rowNumber  = row_q;
    assign conv.column     = col_q;
    assign conv.conv_start = conv_start_q;

    // Next-state logic; coordinates only move on an accepted conv_done.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        wr_en   = 1'b0;
`ifdef CONV_SEQ_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef CONV_SEQ_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (conv.conv_done) begin
                    wr_en = 1'b1;
                    if (col_q == 6'd0) begin
                        col_d   = 6'd1;
                        state_d = ISSUE;
                    end else if (row_q == 6'(OH - 1)) begin
                        state_d = FINISH;
                    end else begin
                        row_d   = row_q + 6'd1;
                        col_d   = 6'd0;
                        state_d = ISSUE;
                    end
                end
`ifdef CONV_SEQ_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    // This idle cycle brings the count to the limit: abort the frame.
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; flags are decoded from the next state so
    // they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            conv_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            busy         <= (state_d != IDLE);
            done         <= (state_d == FINISH);
            conv_start_q <= (state_d == ISSUE);
        end
    end

`ifdef CONV_SEQ_TIMEOUT_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign timeout_err = err_q;
`else
    assign timeout_err = 1'b0;
`endif

    for (genvar b = 0; b < NBLK; b++) begin : g_blk
        conv_blk_reg #(.BW(HB)) u_blk (
            .clk   (clk),
            .reset (reset),
            .wr_en (wr_en && (blk_idx == 7'(b))),
            .d     (conv.conv_result),
            .q     (blk_q[b])
        );
    end

    // Pack half-row slices so half-row 0 lands in the top bits of the map.
    always_comb begin
        out_image = '0;
        for (int b = 0; b < NBLK; b++) begin
            out_image[IMG_W-1-b*HB -: HB] = blk_q[b];
        end
    end
endmodule

// File: tb/tb_conv_row_sequencer.sv
// Randomized bench for conv_row_sequencer: plays the conv array, keeps an
// element-level model of the output map and checks coordinates, timing,
// done/busy behaviour, reset abort and the optional watchdog.
`timescale 1ns/1ps
module tb_conv_row_sequencer;
    localparam int DW    = 4;
    localparam int H     = 16;
    localparam int W     = 16;
    localparam int F     = 5;
    localparam int TO    = 255;
    localparam int OW    = W - F + 1;
    localparam int OH    = H - F + 1;
    localparam int HALF  = OW / 2;
    localparam int HB    = HALF * DW;
    localparam int IMG_W = OH * OW * DW;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             busy, done, timeout_err;
    logic [IMG_W-1:0] out_image;

    conv_row_sequencer_if #(.DATA_WIDTH(DW), .HALF(HALF)) cif ();

    conv_row_sequencer #(
        .DATA_WIDTH(DW), .H(H), .W(W), .F(F), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .conv        (cif.master),
        .out_image   (out_image),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int exp_img [OH][OW];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int img_el(input int r, input int c);
        return int'(out_image[IMG_W-1-(r*OW+c)*DW -: DW]);
    endfunction

    task automatic check_img(input string tag);
        for (int r = 0; r < OH; r++)
            for (int c = 0; c < OW; c++)
                chk(tag, img_el(r, c), exp_img[r][c]);
    endtask

    task automatic clear_model();
        for (int r = 0; r < OH; r++)
            for (int c = 0; c < OW; c++)
                exp_img[r][c] = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_cstart"}, int'(cif.conv_start), 0);
        chk({tag, "_row"}, int'(cif.rowNumber), 0);
        chk({tag, "_col"}, int'(cif.column), 0);
        chk({tag, "_err"}, int'(timeout_err), 0);
        chk({tag, "_img"}, int'(out_image != '0), 0);
    endtask

    // lmode: 0 = 3-cycle latency pattern data, 1 = 1-cycle latency pattern
    // data, 2 = random latency and random data. noise injects ignored
    // start/conv_done pulses. abort_blk >= 0 resets in that block's WAIT.
    task automatic run_frame(input int lmode, input bit noise, input int abort_blk);
        int issued = 0, pend = 0, cur = 0, exp_busy = 0, busy_cyc = 0;
        int cd_cyc = -10, cyc = 0, lat;
        bit fin = 1'b0;
        logic [HB-1:0] res;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!fin && cyc < 3000) begin
            cyc++;
            cif.conv_done   = 1'b0;
            cif.conv_result = HB'($urandom);
            if (done) begin
                chk("done_timing", cyc, cd_cyc + 1);
                chk("blk_count", issued, 2 * OH);
                chk("issue_wait_cycles", busy_cyc, exp_busy);
                chk("busy_in_finish", int'(busy), 1);
                fin = 1'b1;
                if (noise) start = 1'b1;
            end else begin
                chk("busy_mid_frame", int'(busy), 1);
                busy_cyc++;
                if (pend > 0) begin
                    chk("row_stable", int'(cif.rowNumber), cur / 2);
                    chk("col_stable", int'(cif.column), cur % 2);
                    pend--;
                    if (pend == 0) begin
                        if (lmode == 2) res = HB'($urandom);
                        else for (int k = 0; k < HALF; k++) res[HB-1-k*DW -: DW] = DW'(cur & 15);
                        cif.conv_done   = 1'b1;
                        cif.conv_result = res;
                        for (int k = 0; k < HALF; k++)
                            exp_img[cur/2][(cur%2)*HALF+k] = int'(res[HB-1-k*DW -: DW]);
                        cd_cyc = cyc;
                    end else if (noise) begin
                        start = 1'($urandom_range(0, 1));
                    end
                end
                if (cif.conv_start) begin
                    chk("issue_row", int'(cif.rowNumber), issued / 2);
                    chk("issue_col", int'(cif.column), issued % 2);
                    cur = issued;
                    issued++;
                    lat = (lmode == 0) ? 3 : (lmode == 1) ? 1 : int'($urandom_range(1, 5));
                    pend = lat;
                    exp_busy += 1 + lat;
                    if (noise) cif.conv_done = 1'b1;
                    if (cur == abort_blk) begin
                        tick();
                        cif.conv_done = 1'b0;
                        chk("abort_row", int'(cif.rowNumber), cur / 2);
                        chk("abort_col", int'(cif.column), cur % 2);
                        rst_n = 1'b0;
                        #1;
                        check_all_zero("abort");
                        clear_model();
                        return;
                    end
                end
            end
            tick();
        end
        if (!fin) chk("frame_timeout", 0, 1);
        start = 1'b0;
        cif.conv_done = noise;
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);
        check_img("img_after_frame");
    endtask

    task automatic run_stall();
        bit saw_done = 1'b0;
        start = 1'b1;
        cif.conv_done = 1'b0;
        tick();
        start = 1'b0;
        chk("stall_issue", int'(cif.conv_start), 1);
`ifdef CONV_SEQ_TIMEOUT_EN
        for (int i = 0; i < TO; i++) begin
            tick();
            saw_done |= done;
        end
        chk("to_busy_last_wait", int'(busy), 1);
        chk("to_err_before", int'(timeout_err), 0);
        tick();
        chk("to_busy_after", int'(busy), 0);
        chk("to_err_set", int'(timeout_err), 1);
        repeat (5) begin
            tick();
            saw_done |= done;
        end
        chk("to_err_sticky", int'(timeout_err), 1);
`else
        repeat (300) begin
            tick();
            saw_done |= done;
        end
        chk("stall_busy", int'(busy), 1);
        chk("stall_err", int'(timeout_err), 0);
`endif
        chk("stall_no_done", int'(saw_done), 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        clear_model();
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit act;
        rst_n = 1'b1;
        start = 1'b0;
        cif.conv_done = 1'b0;
        cif.conv_result = '0;
        clear_model();

        // Reset asserted mid-idle, then a quiet idle period.
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        tick();
        rst_n = 1'b1;
        act = 1'b0;
        repeat (10) begin
            tick();
            act |= busy | done | cif.conv_start;
        end
        chk("idle_no_activity", int'(act), 0);

        // Full frame, 3-cycle latency, pattern data.
        run_frame(0, 1'b0, -1);

        // Same with ignored start/conv_done noise, then garbage conv_done in idle.
        run_frame(0, 1'b1, -1);
        repeat (3) begin
            cif.conv_done = 1'b1;
            cif.conv_result = HB'($urandom);
            tick();
        end
        cif.conv_done = 1'b0;
        chk("idle_noise_busy", int'(busy), 0);
        check_img("img_idle_noise");

        // Random latencies and data.
        run_frame(2, 1'b1, -1);

        // Reset in WAIT of row 5 / column 1, then a clean restart.
        run_frame(2, 1'b0, 11);
        tick();
        rst_n = 1'b1;
        tick();
        check_all_zero("post_abort");
        run_frame(0, 1'b0, -1);

        // Watchdog / indefinite WAIT.
        run_stall();

        // Back-to-back frames, 1-cycle latency.
        run_frame(1, 1'b0, -1);
        run_frame(1, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
